rs_encoder_204_188: RTL and testbench
=====================================

Name: rs_encoder_204_188

Overview:
- Systematic shortened Reed-Solomon RS(204,188, t=8) encoder over GF(256). It is the transmit-side counterpart of the RS decoder chain (syndrome, error locator, Chien/Forney).
- Accepts a byte stream of K data bytes per packet and passes the data through unchanged. It then appends 16 parity bytes computed by a byte-serial LFSR division by the code generator polynomial.
- Sits between the transport-stream energy-dispersal stage and the outer interleaver. It also serves as the packet source for decoder-chain regression.

Parameters:
- K, 188, data bytes per packet (1..239). Parity count is fixed at 16.
- PRIM_POLY, 9'h11D, field polynomial x^8+x^4+x^3+x^2+1, matching the decoder's alpha/tuple tables.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- In_Valid  in  1  In_Data/In_Sop valid.
- In_Sop  in  1  first byte of a packet.
- In_Data  in  8  data byte.
- In_Ready  out  1  encoder accepts a byte this cycle.
- Out_Valid  out  1  Out_Data valid.
- Out_Data  out  8  codeword byte (data, then parity).
- Out_Sop  out  1  first byte of a codeword.
- Out_Eop  out  1  last (204th, i.e. K+16-th) byte of a codeword.
- Out_Ready  in  1  downstream accepts the byte.

Behaviour:
- Reset (Reset=0, asynchronous) sets the following; operation resumes on the first Clk edge after release:
  - Out_Valid=0, Out_Data=0, Out_Sop=0, Out_Eop=0, In_Ready=0.
  - State=IDLE, all 16 LFSR registers r0..r15=0, byte counter=0.
- Generator: g(x) = prod_{i=0..15}(x + lambda^i), lambda=0x02. Coefficients g0..g15 (monic x^16 implied) are constant GF(256) values. The multiplier is constant-coefficient XOR logic derived from PRIM_POLY; there are no memory tables and no $readmem.
- Transfer occurs on a rising edge when In_Valid && In_Ready; output advances when Out_Valid && Out_Ready.
- Output register: one stage. Out_* may load when !Out_Valid || Out_Ready (the "free" condition).
- In_Ready = free && (state != PARITY).
- State IDLE:
  - In_Ready follows the free condition.
  - A transferred byte with In_Sop=0 is discarded, with no output and no LFSR change.
  - A transferred byte with In_Sop=1 is processed as data byte 0, emitted with Out_Sop=1, and moves the state to DATA with counter=1.
- State DATA:
  - Each transferred byte is emitted unchanged on the next cycle.
  - In_Sop is ignored.
  - The LFSR updates with feedback f = In_Data ^ r15: r_j <= r_{j-1} ^ g_j*f for j=1..15, and r0 <= g0*f.
  - Counter increments. When byte K-1 transfers, the state moves to PARITY with counter=0; the LFSR holds the final remainder after that edge.
- State PARITY:
  - In_Ready=0.
  - While free, emit r15, then shift r_j <= r_{j-1}, r0 <= 0.
  - The counter counts 0..15. Out_Eop=1 on parity byte 15, after which the state returns to IDLE.
  - The LFSR is all-zero on exit.
- Latency: input byte to Out_Data is 1 cycle. The first parity byte appears in the cycle after the last data byte leaves the output register.
- Throughput: with Out_Ready held at 1, a packet takes K+16 cycles, with no bubble between data and parity. The next In_Sop can be accepted in the cycle Out_Eop is presented.
- Backpressure: Out_Ready=0 holds Out_* stable and freezes the LFSR and counter in all states. No byte is lost or duplicated.
- Out_Sop and Out_Eop are asserted only while Out_Valid=1 and are never high in the same beat.
- Reset mid-packet (in DATA or PARITY) aborts the packet: outputs clear immediately, and the partial codeword is never completed.

Test Plan:
- All-zero packet of K=188 bytes, Out_Ready=1 -> 204 output bytes, all 0x00. Out_Sop on beat 0, Out_Eop on beat 203, In_Ready=0 for exactly 16 cycles.
- Packet with bytes 0..186 =0x00 and byte 187 =0x01 -> parity bytes equal g15, g14, ..., g0 in that order (remainder of x^16 mod g).
- 100 random packets encoded, then fed through the syndrome calculator -> S1..S16 all 0x00. The error locator then gives Sigma1..Sigma8 = 0.
- Random Out_Ready duty of 30% over 3 packets -> the output sequence is identical to the Out_Ready=1 run, with Out_* stable whenever Out_Valid && !Out_Ready.
- Five bytes without In_Sop while IDLE, then a valid packet -> the five bytes are discarded and the output equals the single-packet reference.
- Reset asserted at data byte 100, then a fresh packet -> Out_Valid=0 asynchronously. The fresh codeword matches the reference, with no residue from the aborted LFSR state.

Source files
------------

// File: rtl/rs_encoder_204_188.sv
// Systematic shortened RS(204,188) encoder over GF(256). Data passes straight through,
// then 16 parity bytes are shifted out of a byte-serial LFSR that divides by g(x).
module rs_encoder_204_188 #(
  parameter int         K         = 188,
  parameter logic [8:0] PRIM_POLY = 9'h11D
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  input  logic       in_sop_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_sop_o,
  output logic       out_eop_o,
  input  logic       out_ready_i
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // Expand prod (x + alpha^i), i=0..15, at elaboration; returns g0..g15 (monic term implied).
  function automatic logic [127:0] gen_g();
    logic [16:0][7:0] c;
    logic [7:0]       root;
    c    = '0;
    c[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k > 0; k--) c[k] = c[k-1] ^ gf_mul(c[k], root);
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, 8'h02);
    end
    return c[15:0];
  endfunction

  localparam logic [127:0] G_PACKED = gen_g();
  localparam logic [7:0]   K_LAST   = 8'(K - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q [16];
  logic [7:0] lfsr_d [16];
  logic [7:0] lfsr_upd [16];
  logic       run_q;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;

  logic       free;
  logic       take;
  logic [7:0] fb;

  assign free       = !out_valid_q || out_ready_i;
  assign in_ready_o = run_q && free && (state_q != PARITY);
  assign take       = in_valid_i && in_ready_o;
  assign fb         = in_data_i ^ lfsr_q[15];

  for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
    localparam logic [7:0] GC = G_PACKED[8*gi +: 8];
    if (gi == 0) begin : g_first
      assign lfsr_upd[gi] = gf_mul(GC, fb);
    end else begin : g_rest
      assign lfsr_upd[gi] = lfsr_q[gi-1] ^ gf_mul(GC, fb);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (free) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        // In IDLE only a start-of-packet byte opens a codeword; cnt_q is 0 there.
        if (take && (state_q == DATA || in_sop_i)) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data_i;
          out_sop_d   = (state_q == IDLE);
          lfsr_d      = lfsr_upd;
          if (cnt_q == K_LAST) begin
            state_d = PARITY;
            cnt_d   = 8'd0;
          end else begin
            state_d = DATA;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      PARITY: begin
        if (free) begin
          out_valid_d = 1'b1;
          out_data_d  = lfsr_q[15];
          out_eop_d   = (cnt_q == 8'd15);
          for (int j = 15; j > 0; j--) lfsr_d[j] = lfsr_q[j-1];
          lfsr_d[0] = 8'h00;
          if (cnt_q == 8'd15) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      for (int j = 0; j < 16; j++) lfsr_q[j] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      for (int j = 0; j < 16; j++) lfsr_q[j] <= lfsr_d[j];
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;

endmodule

// File: tb/tb_rs_encoder_204_188.sv
// Directed bench for rs_encoder_204_188: reference packets, syndrome checks, backpressure,
// junk-before-SOP and mid-packet reset.
module tb_rs_encoder_204_188;
  localparam int K = 188;
  localparam int N = 204;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  rs_encoder_204_188 #(.K(K), .PRIM_POLY(9'h11D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_sop_i(in_sop), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sop_o(out_sop), .out_eop_o(out_eop),
    .out_ready_i(out_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] gexp [256];
  int         glog [256];
  logic [7:0] gc   [17];
  logic [7:0] cur  [K];
  logic [7:0] pk   [3][K];
  logic [9:0] beats [$];
  logic [9:0] refq  [$];
  int         rdy_mode = 0;
  bit         ilow_en = 0;
  int         ilow_cnt = 0;
  bit         prev_stall = 0;
  logic [10:0] prev_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic int synd_nz(input int off);
    int cnt = 0;
    if (beats.size() < off + N) return 16;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] s = 8'h00;
      for (int n = 0; n < N; n++) s = mul(s, gexp[i]) ^ beats[off+n][7:0];
      if (s != 0) cnt++;
    end
    return cnt;
  endfunction

  function automatic int cmp_ref(input int ref_off, input int n);
    int bad = 0;
    if (beats.size() < n || refq.size() < ref_off + n) return n;
    for (int i = 0; i < n; i++) if (beats[i] !== refq[ref_off+i]) bad++;
    return bad;
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("stall_hold", {21'd0, out_valid, out_sop, out_eop, out_data}, {21'd0, prev_beat});
      if (out_valid) check("sop_eop_excl", {31'd0, out_sop & out_eop}, 32'd0);
      if (out_valid && out_ready) beats.push_back({out_sop, out_eop, out_data});
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_valid, out_sop, out_eop, out_data};
      if (ilow_en && !in_ready) ilow_cnt++;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sop);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cur(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(cur[i], i == 0);
  endtask

  task automatic wait_beats(input int n, input string tag);
    for (int i = 0; i < 20000 && beats.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) begin @(posedge clk); #1; end
    check(tag, beats.size(), n);
  endtask

  initial begin
    int nz, sops, eops;
    logic [7:0] x;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    gexp[255] = 8'h01;
    glog[0] = 0;
    for (int k = 0; k < 17; k++) gc[k] = 8'h00;
    gc[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k > 0; k--) gc[k] = gc[k-1] ^ mul(gc[k], gexp[i]);
      gc[0] = mul(gc[0], gexp[i]);
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < K; i++) pk[p][i] = 8'($urandom_range(0, 255));

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sop", {31'd0, out_sop}, 32'd0);
    check("rst_out_eop", {31'd0, out_eop}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero packet
    for (int i = 0; i < K; i++) cur[i] = 8'h00;
    beats.delete();
    ilow_cnt = 0;
    ilow_en  = 1;
    send_cur(K);
    in_valid = 1'b0;
    wait_beats(N, "zero_len");
    ilow_en = 0;
    check("zero_in_ready_low", ilow_cnt, 16);
    nz = 0; sops = 0; eops = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i][7:0] != 0) nz++;
      if (beats[i][9]) sops++;
      if (beats[i][8]) eops++;
    end
    check("zero_data", nz, 0);
    check("zero_sop_cnt", sops, 1);
    check("zero_eop_cnt", eops, 1);
    if (beats.size() == N) begin
      check("zero_sop_beat0", {31'd0, beats[0][9]}, 32'd1);
      check("zero_eop_beat203", {31'd0, beats[N-1][8]}, 32'd1);
    end

    // Impulse packet: parity equals g15..g0
    cur[K-1] = 8'h01;
    beats.delete();
    send_cur(K);
    in_valid = 1'b0;
    wait_beats(N, "imp_len");
    if (beats.size() == N) begin
      for (int j = 0; j < 16; j++) check($sformatf("imp_parity%0d", j), {24'd0, beats[K+j][7:0]}, {24'd0, gc[15-j]});
      check("imp_data_last", {24'd0, beats[K-1][7:0]}, 32'd1);
    end
    check("imp_syndrome", synd_nz(0), 0);

    // Three random packets back to back, Out_Ready=1 reference run
    beats.delete();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < K; i++) cur[i] = pk[p][i];
      send_cur(K);
    end
    in_valid = 1'b0;
    wait_beats(3*N, "rand_len");
    for (int p = 0; p < 3; p++) begin
      check($sformatf("rand_syndrome%0d", p), synd_nz(p*N), 0);
      if (beats.size() == 3*N) begin
        for (int i = 0; i < K; i++) if (beats[p*N+i][7:0] != pk[p][i]) nz++;
        check($sformatf("rand_sop%0d", p), {31'd0, beats[p*N][9]}, 32'd1);
        check($sformatf("rand_eop%0d", p), {31'd0, beats[p*N+N-1][8]}, 32'd1);
      end
    end
    check("rand_passthru", nz, 0);
    refq = beats;

    // Same packets under 30% Out_Ready duty
    rdy_mode = 1;
    beats.delete();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < K; i++) cur[i] = pk[p][i];
      send_cur(K);
    end
    in_valid = 1'b0;
    wait_beats(3*N, "bp_len");
    check("bp_vs_ref", cmp_ref(0, 3*N), 0);
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Junk bytes without SOP while idle, then a valid packet
    beats.delete();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < K; i++) cur[i] = pk[0][i];
    send_cur(K);
    in_valid = 1'b0;
    wait_beats(N, "junk_len");
    check("junk_vs_ref", cmp_ref(0, N), 0);

    // Reset mid-packet after 100 data bytes, then a fresh packet
    beats.delete();
    for (int i = 0; i < K; i++) cur[i] = pk[1][i];
    send_cur(100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beats.delete();
    for (int i = 0; i < K; i++) cur[i] = pk[2][i];
    send_cur(K);
    in_valid = 1'b0;
    wait_beats(N, "post_rst_len");
    check("post_rst_vs_ref", cmp_ref(2*N, N), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
